// File: rtl/wb_csr_commit_arbiter.sv
// Commits the CSR writes of the two writeback lanes to the single CSR write port in program order.
// A same-cycle pair of writes is split over two cycles, and the extra cycle stalls WB allow-in.
module wb_csr_commit_arbiter #(
    parameter int unsigned CSR_ADDR_W = 14,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  l0_valid_i,
    input  logic                  l0_csr_we_i,
    input  logic [CSR_ADDR_W-1:0] l0_csr_waddr_i,
    input  logic [DATA_W-1:0]     l0_csr_wdata_i,
    input  logic                  l0_excep_i,
    input  logic                  l1_valid_i,
    input  logic                  l1_csr_we_i,
    input  logic [CSR_ADDR_W-1:0] l1_csr_waddr_i,
    input  logic [DATA_W-1:0]     l1_csr_wdata_i,
    input  logic                  l1_excep_i,
    output logic                  wb_allowin_o,
    output logic                  csr_we_o,
    output logic [CSR_ADDR_W-1:0] csr_waddr_o,
    output logic [DATA_W-1:0]     csr_wdata_o,
    output logic                  flush_o,
    output logic                  l1_kill_o,
    output logic [CNT_W-1:0]      stall_cnt_o
);

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t                  state;
    logic [CSR_ADDR_W-1:0]   hold_addr;
    logic [DATA_W-1:0]       hold_data;
    logic [CNT_W-1:0]        stall_cnt;

    logic l0_exc;
    logic l1_exc;
    logic w0;
    logic w1;
    logic both;

    // Effective per-lane requests; a lane-0 exception squashes everything in lane 1.
    always_comb begin
        l0_exc = l0_valid_i & l0_excep_i;
        l1_exc = l1_valid_i & l1_excep_i;
        w0     = l0_valid_i & l0_csr_we_i & ~l0_excep_i;
        w1     = l1_valid_i & l1_csr_we_i & ~l1_excep_i & ~l0_exc;
        both   = (state == IDLE) & w0 & w1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            hold_addr <= '0;
            hold_data <= '0;
            stall_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (both) begin
                        state     <= DRAIN;
                        hold_addr <= l1_csr_waddr_i;
                        hold_data <= l1_csr_wdata_i;
                        if (!(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
                    end
                end
                DRAIN:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Write port and flush signalling are zero-latency from the lane inputs.
    always_comb begin
        csr_we_o     = 1'b0;
        csr_waddr_o  = l0_csr_waddr_i;
        csr_wdata_o  = l0_csr_wdata_i;
        flush_o      = 1'b0;
        l1_kill_o    = 1'b0;
        wb_allowin_o = 1'b1;
        if (!rst_n) begin
            csr_waddr_o = '0;
            csr_wdata_o = '0;
        end else if (state == DRAIN) begin
            csr_we_o    = 1'b1;
            csr_waddr_o = hold_addr;
            csr_wdata_o = hold_data;
        end else begin
            flush_o      = l0_exc | l1_exc;
            l1_kill_o    = l0_exc & l1_valid_i;
            wb_allowin_o = ~(w0 & w1);
            if (w0) begin
                csr_we_o = 1'b1;
            end else if (w1) begin
                csr_we_o    = 1'b1;
                csr_waddr_o = l1_csr_waddr_i;
                csr_wdata_o = l1_csr_wdata_i;
            end
        end
    end

    assign stall_cnt_o = stall_cnt;

endmodule

// File: tb/tb_wb_csr_commit_arbiter.sv
// Bench for wb_csr_commit_arbiter: directed scenarios plus a randomized run against a
// queue-based model of in-order commit (small counter width so saturation is reachable).
module tb_wb_csr_commit_arbiter;

    localparam int unsigned AW = 14;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          l0_valid_i, l0_csr_we_i, l0_excep_i;
    logic [AW-1:0] l0_csr_waddr_i;
    logic [DW-1:0] l0_csr_wdata_i;
    logic          l1_valid_i, l1_csr_we_i, l1_excep_i;
    logic [AW-1:0] l1_csr_waddr_i;
    logic [DW-1:0] l1_csr_wdata_i;
    logic          wb_allowin_o, csr_we_o, flush_o, l1_kill_o;
    logic [AW-1:0] csr_waddr_o;
    logic [DW-1:0] csr_wdata_o;
    logic [CW-1:0] stall_cnt_o;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    always #5 clk = ~clk;

    wb_csr_commit_arbiter #(.CSR_ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .l0_valid_i(l0_valid_i), .l0_csr_we_i(l0_csr_we_i), .l0_csr_waddr_i(l0_csr_waddr_i),
        .l0_csr_wdata_i(l0_csr_wdata_i), .l0_excep_i(l0_excep_i),
        .l1_valid_i(l1_valid_i), .l1_csr_we_i(l1_csr_we_i), .l1_csr_waddr_i(l1_csr_waddr_i),
        .l1_csr_wdata_i(l1_csr_wdata_i), .l1_excep_i(l1_excep_i),
        .wb_allowin_o(wb_allowin_o), .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o),
        .csr_wdata_o(csr_wdata_o), .flush_o(flush_o), .l1_kill_o(l1_kill_o),
        .stall_cnt_o(stall_cnt_o)
    );

    task automatic drive(input logic v0, we0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input logic e0, input logic v1, we1, input logic [AW-1:0] a1,
                         input logic [DW-1:0] d1, input logic e1);
        l0_valid_i = v0; l0_csr_we_i = we0; l0_csr_waddr_i = a0; l0_csr_wdata_i = d0; l0_excep_i = e0;
        l1_valid_i = v1; l1_csr_we_i = we1; l1_csr_waddr_i = a1; l1_csr_wdata_i = d1; l1_excep_i = e1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1, 1, 14'h011, 32'h55, 0, 1, 1, 14'h022, 32'h66, 0);
        next_cycle();
        @(negedge clk);
        vectors++; if (csr_we_o !== 1'b0) begin miscompares++; $display("FAIL reset_we got %b exp 0", csr_we_o); end
        vectors++; if (csr_waddr_o !== 14'h0 || csr_wdata_o !== 32'h0) begin miscompares++; $display("FAIL reset_port got %h/%h exp 0/0", csr_waddr_o, csr_wdata_o); end
        vectors++; if (flush_o !== 1'b0 || l1_kill_o !== 1'b0) begin miscompares++; $display("FAIL reset_flush got %b%b exp 00", flush_o, l1_kill_o); end
        vectors++; if (wb_allowin_o !== 1'b1) begin miscompares++; $display("FAIL reset_allowin got %b exp 1", wb_allowin_o); end
        vectors++; if (stall_cnt_o !== 3'd0) begin miscompares++; $display("FAIL reset_cnt got %0d exp 0", stall_cnt_o); end
        next_cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_lane0_only();
        drive(1, 1, 14'h006, 32'h1234, 0, 0, 0, 14'h0, 32'h0, 0);
        @(negedge clk);
        vectors++; if (csr_we_o !== 1'b1 || csr_waddr_o !== 14'h006 || csr_wdata_o !== 32'h1234) begin miscompares++; $display("FAIL l0_only_port got %b %h %h exp 1 006 1234", csr_we_o, csr_waddr_o, csr_wdata_o); end
        vectors++; if (wb_allowin_o !== 1'b1 || flush_o !== 1'b0) begin miscompares++; $display("FAIL l0_only_ctl got allow %b flush %b exp 1 0", wb_allowin_o, flush_o); end
        next_cycle();
        drive(0, 0, 14'h0, 32'h0, 0, 0, 0, 14'h0, 32'h0, 0);
        @(negedge clk);
        vectors++; if (csr_we_o !== 1'b0 || stall_cnt_o !== 3'd0) begin miscompares++; $display("FAIL l0_only_after got we %b cnt %0d exp 0 0", csr_we_o, stall_cnt_o); end
        next_cycle();
    endtask

    task automatic test_both_write();
        drive(1, 1, 14'h000, 32'hA, 0, 1, 1, 14'h001, 32'hB, 0);
        @(negedge clk);
        vectors++; if (csr_we_o !== 1'b1 || csr_waddr_o !== 14'h000 || csr_wdata_o !== 32'hA || wb_allowin_o !== 1'b0) begin miscompares++; $display("FAIL both_c0 got %b %h %h allow %b exp 1 000 a 0", csr_we_o, csr_waddr_o, csr_wdata_o, wb_allowin_o); end
        next_cycle();
        @(negedge clk);
        vectors++; if (csr_we_o !== 1'b1 || csr_waddr_o !== 14'h001 || csr_wdata_o !== 32'hB || wb_allowin_o !== 1'b1) begin miscompares++; $display("FAIL both_c1 got %b %h %h allow %b exp 1 001 b 1", csr_we_o, csr_waddr_o, csr_wdata_o, wb_allowin_o); end
        vectors++; if (stall_cnt_o !== 3'd1 || flush_o !== 1'b0) begin miscompares++; $display("FAIL both_cnt got cnt %0d flush %b exp 1 0", stall_cnt_o, flush_o); end
        next_cycle();
        drive(0, 0, 14'h0, 32'h0, 0, 0, 0, 14'h0, 32'h0, 0);
        @(negedge clk);
        vectors++; if (csr_we_o !== 1'b0) begin miscompares++; $display("FAIL both_after got we %b exp 0", csr_we_o); end
        next_cycle();
    endtask

    task automatic test_l0_excep();
        drive(1, 0, 14'h003, 32'h3, 1, 1, 1, 14'h004, 32'h4, 0);
        @(negedge clk);
        vectors++; if (flush_o !== 1'b1 || l1_kill_o !== 1'b1 || csr_we_o !== 1'b0 || wb_allowin_o !== 1'b1) begin miscompares++; $display("FAIL l0_exc got flush %b kill %b we %b allow %b exp 1 1 0 1", flush_o, l1_kill_o, csr_we_o, wb_allowin_o); end
        next_cycle();
        drive(0, 0, 14'h0, 32'h0, 0, 0, 0, 14'h0, 32'h0, 0);
        @(negedge clk);
        vectors++; if (csr_we_o !== 1'b0 || stall_cnt_o !== 3'd1) begin miscompares++; $display("FAIL l0_exc_after got we %b cnt %0d exp 0 1", csr_we_o, stall_cnt_o); end
        next_cycle();
    endtask

    task automatic test_l1_excep();
        drive(1, 1, 14'h005, 32'h7, 0, 1, 1, 14'h009, 32'h9, 1);
        @(negedge clk);
        vectors++; if (csr_we_o !== 1'b1 || csr_waddr_o !== 14'h005 || csr_wdata_o !== 32'h7 || flush_o !== 1'b1) begin miscompares++; $display("FAIL l1_exc got %b %h %h flush %b exp 1 005 7 1", csr_we_o, csr_waddr_o, csr_wdata_o, flush_o); end
        next_cycle();
        drive(0, 0, 14'h0, 32'h0, 0, 0, 0, 14'h0, 32'h0, 0);
        @(negedge clk);
        vectors++; if (csr_we_o !== 1'b0 || flush_o !== 1'b0) begin miscompares++; $display("FAIL l1_exc_after got we %b flush %b exp 0 0", csr_we_o, flush_o); end
        next_cycle();
    endtask

    task automatic test_invalid_lane0();
        drive(0, 1, 14'h011, 32'h11, 1, 1, 1, 14'h022, 32'h33, 0);
        @(negedge clk);
        vectors++; if (csr_we_o !== 1'b1 || csr_waddr_o !== 14'h022 || csr_wdata_o !== 32'h33 || flush_o !== 1'b0 || l1_kill_o !== 1'b0) begin miscompares++; $display("FAIL inv_l0 got %b %h %h flush %b kill %b exp 1 022 33 0 0", csr_we_o, csr_waddr_o, csr_wdata_o, flush_o, l1_kill_o); end
        next_cycle();
    endtask

    task automatic test_same_addr();
        logic [DW-1:0] csr_val;
        csr_val = 32'hDEAD;
        drive(1, 1, 14'h040, 32'h1, 0, 1, 1, 14'h040, 32'h2, 0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            if (csr_we_o === 1'b1 && csr_waddr_o === 14'h040) csr_val = csr_wdata_o;
            next_cycle();
        end
        vectors++; if (csr_val !== 32'h2) begin miscompares++; $display("FAIL same_addr got %h exp 2", csr_val); end
        drive(0, 0, 14'h0, 32'h0, 0, 0, 0, 14'h0, 32'h0, 0);
    endtask

    task automatic test_reset_in_drain();
        drive(1, 1, 14'h010, 32'h10, 0, 1, 1, 14'h020, 32'h20, 0);
        next_cycle();
        rst_n = 1'b0;
        @(negedge clk);
        vectors++; if (csr_we_o !== 1'b0) begin miscompares++; $display("FAIL rst_drain_we got %b exp 0", csr_we_o); end
        next_cycle();
        rst_n = 1'b1;
        drive(0, 0, 14'h0, 32'h0, 0, 0, 0, 14'h0, 32'h0, 0);
        @(negedge clk);
        vectors++; if (csr_we_o !== 1'b0 || stall_cnt_o !== 3'd0) begin miscompares++; $display("FAIL rst_drain_after got we %b cnt %0d exp 0 0", csr_we_o, stall_cnt_o); end
        next_cycle();
    endtask

    task automatic test_saturation();
        drive(1, 1, 14'h001, 32'h1, 0, 1, 1, 14'h002, 32'h2, 0);
        for (int p = 0; p < 9; p++) begin
            next_cycle();
            next_cycle();
        end
        drive(0, 0, 14'h0, 32'h0, 0, 0, 0, 14'h0, 32'h0, 0);
        @(negedge clk);
        vectors++; if (stall_cnt_o !== 3'd7) begin miscompares++; $display("FAIL saturate got %0d exp 7", stall_cnt_o); end
        next_cycle();
    endtask

    task automatic test_random();
        wr_t           pend[$];
        wr_t           q[$];
        logic [CW-1:0] cnt;
        logic          e_we, e_flush, e_kill, e_allow, ex0;
        logic [AW-1:0] e_a;
        logic [DW-1:0] e_d;
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        cnt = '0;
        for (int i = 0; i < 2000; i++) begin
            rst_n = ($urandom_range(0, 99) >= 4);
            drive($urandom_range(0, 99) < 75, $urandom_range(0, 99) < 60, AW'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 99) < 15,
                  $urandom_range(0, 99) < 75, $urandom_range(0, 99) < 60, AW'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 99) < 15);
            q.delete();
            e_we = 0; e_a = l0_csr_waddr_i; e_d = l0_csr_wdata_i; e_flush = 0; e_kill = 0; e_allow = 1;
            if (!rst_n) begin
                e_a = '0; e_d = '0;
            end else if (pend.size() != 0) begin
                e_we = 1; e_a = pend[0].a; e_d = pend[0].d;
            end else begin
                ex0 = l0_valid_i & l0_excep_i;
                if (l0_valid_i && l0_csr_we_i && !l0_excep_i) q.push_back('{l0_csr_waddr_i, l0_csr_wdata_i});
                if (l1_valid_i && l1_csr_we_i && !l1_excep_i && !ex0) q.push_back('{l1_csr_waddr_i, l1_csr_wdata_i});
                e_flush = ex0 | (l1_valid_i & l1_excep_i);
                e_kill  = ex0 & l1_valid_i;
                e_allow = (q.size() < 2);
                if (q.size() != 0) begin e_we = 1; e_a = q[0].a; e_d = q[0].d; end
            end
            @(negedge clk);
            vectors++; if (csr_we_o !== e_we) begin miscompares++; $display("FAIL rnd%0d we got %b exp %b", i, csr_we_o, e_we); end
            vectors++; if (csr_waddr_o !== e_a) begin miscompares++; $display("FAIL rnd%0d addr got %h exp %h", i, csr_waddr_o, e_a); end
            vectors++; if (csr_wdata_o !== e_d) begin miscompares++; $display("FAIL rnd%0d data got %h exp %h", i, csr_wdata_o, e_d); end
            vectors++; if (flush_o !== e_flush) begin miscompares++; $display("FAIL rnd%0d flush got %b exp %b", i, flush_o, e_flush); end
            vectors++; if (l1_kill_o !== e_kill) begin miscompares++; $display("FAIL rnd%0d kill got %b exp %b", i, l1_kill_o, e_kill); end
            vectors++; if (wb_allowin_o !== e_allow) begin miscompares++; $display("FAIL rnd%0d allowin got %b exp %b", i, wb_allowin_o, e_allow); end
            vectors++; if (stall_cnt_o !== cnt) begin miscompares++; $display("FAIL rnd%0d cnt got %0d exp %0d", i, stall_cnt_o, cnt); end
            next_cycle();
            if (!rst_n) begin
                pend.delete(); cnt = '0;
            end else if (pend.size() != 0) begin
                pend.delete();
            end else if (q.size() == 2) begin
                pend.push_back(q[1]);
                if (cnt != 3'd7) cnt = cnt + 3'd1;
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        drive(0, 0, 14'h0, 32'h0, 0, 0, 0, 14'h0, 32'h0, 0);
        rst_n = 1'b0;
        #1;
        test_reset();
        test_lane0_only();
        test_both_write();
        test_l0_excep();
        test_l1_excep();
        test_invalid_lane0();
        test_same_addr();
        test_reset_in_drain();
        test_saturation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wb_csr_commit_arbiter.md
Name: wb_csr_commit_arbiter

Overview:
- Sits at the end of the dual-issue writeback stage, between the two WB lanes and the single CSR write port.
- Lane 0 is always the older instruction. The block commits each lane's CSR write in program order and suppresses younger writes behind an exception or ertn.
- When both lanes write a CSR in the same cycle, it serialises the lane-1 write into a second cycle and stalls WB allow-in for that cycle.
- It counts serialisation stalls for performance debug.

Parameters:
- CSR_ADDR_W, 14, CSR address width.
- DATA_W, 32, CSR data width.
- CNT_W, 32, width of the stall counter (saturating).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- l0_valid_i  in  1  lane 0 holds a valid instruction in WB
- l0_csr_we_i  in  1  lane 0 requests a CSR write
- l0_csr_waddr_i  in  CSR_ADDR_W  lane 0 CSR address
- l0_csr_wdata_i  in  DATA_W  lane 0 CSR data
- l0_excep_i  in  1  lane 0 raises an exception or ertn
- l1_valid_i, l1_csr_we_i, l1_csr_waddr_i, l1_csr_wdata_i, l1_excep_i  in  same widths as lane 0  lane 1 equivalents
- wb_allowin_o  out  1  WB may accept a new pair next cycle
- csr_we_o  out  1  CSR write port enable
- csr_waddr_o  out  CSR_ADDR_W  CSR write port address
- csr_wdata_o  out  DATA_W  CSR write port data
- flush_o  out  1  pipeline flush, caused by lane 0 or lane 1 exception/ertn
- l1_kill_o  out  1  lane 1 squashed; all lane-1 side effects are suppressed
- stall_cnt_o  out  CNT_W  number of serialisation cycles

Behaviour:
- Clock and reset: single clock clk; rst_n is synchronous, active-low.
- Reset values: state=IDLE, held registers=0, stall_cnt_o=0.
- While rst_n=0, outputs are forced to: csr_we_o=0, csr_waddr_o=0, csr_wdata_o=0, flush_o=0, l1_kill_o=0, wb_allowin_o=1.
- Effective request for lane n: wN = lN_valid_i & lN_csr_we_i & ~lN_excep_i. Lane 1 is additionally gated by ~(l0_valid_i & l0_excep_i).
- States: IDLE and DRAIN.
- IDLE, lane 0 exception (l0_valid_i & l0_excep_i):
  - flush_o=1; l1_kill_o=l1_valid_i; csr_we_o=0.
  - Stay in IDLE.
- IDLE, lane 1 exception only (l1_valid_i & l1_excep_i, lane 0 clean):
  - flush_o=1; lane 0 write proceeds if w0; lane 1 write is suppressed.
  - Stay in IDLE.
- IDLE, single write (w0 xor w1): drive that lane's address/data on the port with csr_we_o=1, same cycle (combinational, zero latency). A lane-1-only write is legal even when l0_valid_i=0.
- IDLE, both write (w0 & w1):
  - This cycle: port carries lane 0's write; lane 1's address/data are latched into hold registers; wb_allowin_o=0.
  - Next state DRAIN; stall_cnt_o increments (saturates at all-ones).
- DRAIN:
  - Port carries the held lane-1 write, csr_we_o=1; flush_o=0; wb_allowin_o=1.
  - Lane inputs are ignored; upstream holds them stable.
  - Next state IDLE unconditionally.
- IDLE with no request: csr_we_o=0; wb_allowin_o=1; outputs csr_waddr_o/csr_wdata_o are don't-care but are driven with lane 0 values.
- Same address from both lanes: two writes land in order, so the final CSR value is lane 1's.
- Reset asserted in DRAIN: the pending lane-1 write is dropped; next state IDLE.
- Invalid lanes: lN_valid_i=0 disables every effect of that lane, including its exception.

Test Plan:
- Lane 0 only: l0_valid=1, we=1, addr=0x006, data=0x1234 -> same cycle csr_we_o=1, addr=0x006, data=0x1234; allowin=1; stall_cnt stays 0.
- Both lanes write: addr 0x000/0x001, data 0xA/0xB -> cycle0 port (0x000,0xA) with allowin=0; cycle1 port (0x001,0xB) with allowin=1; stall_cnt=1.
- Lane 0 exception, lane 1 csr_we=1 -> flush_o=1, l1_kill_o=1, csr_we_o=0; state stays IDLE.
- Lane 1 exception, lane 0 write (0x005,0x7) -> csr_we_o=1 with (0x005,0x7); flush_o=1; no DRAIN cycle.
- Both lanes write 0x040 (data 1 then 2) -> register value after cycle1 is 2.
- rst_n=0 asserted during DRAIN -> next cycle state IDLE, csr_we_o=0, stall_cnt_o=0; the held write is never issued.
